// File: rtl/coef_loader.sv
// Streams packed signed coefficient pairs into the NTT core's dual-port load interface.
// Each coefficient is reduced into [0, Q). The last write is held until the core reports init_done.
module coef_loader #(
  parameter int N      = 256,
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int Q      = 3329,
  parameter int REDUCE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [31:0]   s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          we,
  output logic [AW-1:0] address_ina,
  output logic [AW-1:0] address_inb,
  output logic [DW-1:0] data_ina,
  output logic [DW-1:0] data_inb,
  input  logic          init_done,
  output logic          busy,
  output logic          load_done,
  output logic          range_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_PAIR = AW'(N / 2 - 1);

  // The top bit is the range flag; the low DW bits are the reduced (or raw) value.
  function automatic logic [DW:0] reduce_coef(input logic [15:0] raw);
    logic signed [31:0] x;
    logic [DW-1:0]      r;
    logic               err;
    x = {{16{raw[15]}}, raw};
    if (REDUCE != 0) begin
      if (x < 32'sd0) begin
        r = DW'(x + Q);
      end else if (x >= Q) begin
        r = DW'(x - Q);
      end else begin
        r = DW'(x);
      end
      err = (x < -Q) || (x >= Q + Q);
    end else begin
      r   = DW'(raw);
      err = 1'b0;
    end
    return {err, r};
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          s_ready_q, s_ready_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_a_q, addr_a_d;
  logic [AW-1:0] addr_b_q, addr_b_d;
  logic [DW-1:0] data_a_q, data_a_d;
  logic [DW-1:0] data_b_q, data_b_d;
  logic          busy_q, busy_d;
  logic          load_done_q, load_done_d;
  logic          range_err_q, range_err_d;
  logic          xfer_s;
  logic [DW:0]   red_a_s, red_b_s;

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s_ready_d   = s_ready_q;
    we_d        = 1'b0;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    busy_d      = busy_q;
    load_done_d = load_done_q;
    range_err_d = range_err_q;
    xfer_s      = s_valid && s_ready_q;
    red_a_s     = reduce_coef(s_data[15:0]);
    red_b_s     = reduce_coef(s_data[31:16]);

    case (state_q)
      IDLE, DONE: begin
        if (load_start) begin
          state_d     = LOAD;
          cnt_d       = {AW{1'b0}};
          s_ready_d   = 1'b1;
          busy_d      = 1'b1;
          load_done_d = 1'b0;
          range_err_d = 1'b0;
        end else begin
          state_d   = state_q;
          s_ready_d = 1'b0;
        end
      end
      LOAD: begin
        we_d = xfer_s;
        if (xfer_s) begin
          addr_a_d    = {cnt_q[AW-2:0], 1'b0};
          addr_b_d    = {cnt_q[AW-2:0], 1'b1};
          data_a_d    = red_a_s[DW-1:0];
          data_b_d    = red_b_s[DW-1:0];
          range_err_d = range_err_q | red_a_s[DW] | red_b_s[DW];
          cnt_d       = cnt_q + {{(AW-1){1'b0}}, 1'b1};
          // Stop accepting on the same edge as the final pair so the counter never wraps.
          if (cnt_q == LAST_PAIR) begin
            state_d   = HOLD;
            s_ready_d = 1'b0;
          end else begin
            state_d   = LOAD;
            s_ready_d = 1'b1;
          end
        end else begin
          state_d   = LOAD;
          s_ready_d = 1'b1;
        end
      end
      HOLD: begin
        s_ready_d = 1'b0;
        if (init_done) begin
          state_d     = DONE;
          we_d        = 1'b0;
          busy_d      = 1'b0;
          load_done_d = 1'b1;
        end else begin
          state_d = HOLD;
          we_d    = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = {AW{1'b0}};
        s_ready_d   = 1'b0;
        we_d        = 1'b0;
        busy_d      = 1'b0;
        load_done_d = 1'b0;
        range_err_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything, dropping we at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= {AW{1'b0}};
      s_ready_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_a_q    <= {AW{1'b0}};
      addr_b_q    <= {AW{1'b0}};
      data_a_q    <= {DW{1'b0}};
      data_b_q    <= {DW{1'b0}};
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_ready_q   <= s_ready_d;
      we_q        <= we_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      range_err_q <= range_err_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign we          = we_q;
  assign address_ina = addr_a_q;
  assign address_inb = addr_b_q;
  assign data_ina    = data_a_q;
  assign data_inb    = data_b_q;
  assign busy        = busy_q;
  assign load_done   = load_done_q;
  assign range_err   = range_err_q;

endmodule

// File: tb/tb_coef_loader.sv
// Directed bench for coef_loader: expected writes are queued at drive time and checked when the write appears.
module tb_coef_loader;
  localparam int N  = 256;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int Q  = 3329;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_start = 1'b0;
  logic [31:0]   s_data = 32'd0;
  logic          s_valid = 1'b0;
  logic          init_done = 1'b0;
  logic          s_ready, we, busy, load_done, range_err;
  logic [AW-1:0] address_ina, address_inb;
  logic [DW-1:0] data_ina, data_inb;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [47:0] sb_q[$];
  logic [47:0] last_exp = 48'd0;

  coef_loader #(.N(N), .AW(AW), .DW(DW), .Q(Q), .REDUCE(1)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .we(we), .address_ina(address_ina), .address_inb(address_inb),
    .data_ina(data_ina), .data_inb(data_inb), .init_done(init_done), .busy(busy),
    .load_done(load_done), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference reduction: in-range values are plain mod Q, out-of-range values take one correction step.
  function automatic logic [15:0] red_exp(input logic [15:0] raw);
    int v;
    int r;
    v = $signed(raw);
    if (v >= -Q && v < 2 * Q) r = ((v % Q) + Q) % Q;
    else if (v < 0)            r = v + Q;
    else                       r = v - Q;
    return r[15:0];
  endfunction

  function automatic logic [31:0] rnd_word();
    int a;
    int b;
    a = int'($urandom_range(3 * Q - 1, 0)) - Q;
    b = int'($urandom_range(3 * Q - 1, 0)) - Q;
    return {b[15:0], a[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input int k);
    logic [7:0]  aa;
    logic [7:0]  ab;
    logic [47:0] e;
    aa = 8'(2 * k);
    ab = 8'(2 * k + 1);
    s_data  = w;
    s_valid = 1'b1;
    sb_q.push_back({aa, ab, red_exp(w[15:0]), red_exp(w[31:16])});
    step();
    s_valid = 1'b0;
    chk("we_on_write", 64'(we), 64'd1);
    e = sb_q.pop_front();
    last_exp = e;
    chk("write_pair", 64'({address_ina, address_inb, data_ina, data_inb}), 64'(e));
  endtask

  task automatic gap();
    s_valid = 1'b0;
    step();
    chk("we_in_gap", 64'(we), 64'd0);
    chk("held_in_gap", 64'({address_ina, address_inb, data_ina, data_inb}), 64'(last_exp));
  endtask

  initial begin
    #12;
    chk("reset_outputs", 64'({s_ready, we, busy, load_done, range_err, address_ina, address_inb,
                              data_ina, data_inb}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h1234_5678;
    step();
    chk("idle_not_ready", 64'({s_ready, we}), 64'd0);
    s_valid = 1'b0;

    // Full back-to-back load with boundary words at both ends
    pulse_start();
    chk("load_entry", 64'({s_ready, busy, load_done}), 64'b110);
    send(32'hFFFE_0000, 0);
    chk("first_write", 64'({address_ina, address_inb, data_ina, data_inb}), 64'h00_01_0000_0CFF);
    for (int k = 1; k < 127; k++) send(rnd_word(), k);
    send(32'h1A01_F2FF, 127);
    chk("last_write", 64'({address_ina, address_inb, data_ina, data_inb}), 64'hFE_FF_0000_0D00);
    chk("hold_entry", 64'({s_ready, we, busy, range_err}), 64'b0110);

    // HOLD with init_done low; stray s_valid must not be consumed
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_we", 64'({s_ready, we, address_ina, address_inb}), 64'({1'b0, 1'b1, 8'd254, 8'd255}));
    end
    s_valid = 1'b0;
    init_done = 1'b1;
    step();
    init_done = 1'b0;
    chk("done_entry", 64'({we, busy, load_done, range_err}), 64'b0010);

    // Throttled load; load_start and init_done during LOAD are ignored
    pulse_start();
    chk("restart_from_done", 64'({load_done, s_ready, busy}), 64'b011);
    for (int k = 0; k < 128; k++) begin
      if (k == 120) init_done = 1'b1;
      send(rnd_word(), k);
      if (k < 127) begin
        if (k == 40) load_start = 1'b1;
        gap();
        load_start = 1'b0;
        if (k == 40) chk("start_ignored", 64'({busy, load_done}), 64'b10);
      end
    end
    step();
    init_done = 1'b0;
    chk("early_init_done", 64'({we, busy, load_done}), 64'b001);

    // Out-of-range input sets a sticky flag that only a new load clears
    pulse_start();
    send(32'h0D01_8000, 0);
    chk("oor_data", 64'({data_ina, data_inb, range_err}), 64'({16'h8D01, 16'h0000, 1'b1}));
    for (int k = 1; k < 128; k++) send(rnd_word(), k);
    chk("range_sticky", 64'(range_err), 64'd1);
    init_done = 1'b1;
    step();
    init_done = 1'b0;
    chk("done_keeps_err", 64'({load_done, range_err}), 64'b11);
    pulse_start();
    chk("start_clears_err", 64'({load_done, range_err}), 64'b00);

    // Asynchronous reset mid-load discards the partial load
    for (int k = 0; k < 50; k++) send(rnd_word(), k);
    #3;
    rst = 1'b0;
    #1;
    chk("async_reset", 64'({s_ready, we, busy, load_done, range_err, address_ina, address_inb,
                            data_ina, data_inb}), 64'd0);
    #3;
    rst = 1'b1;
    step();
    pulse_start();
    send(rnd_word(), 0);
    chk("restart_addr", 64'({address_ina, address_inb}), 64'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/coef_loader.md
Name: coef_loader

Overview:
- Upstream feeder for the NTT wrap core.
- Accepts a valid/ready stream of 32-bit words, each holding two packed signed 16-bit coefficients.
- Reduces each coefficient into [0, Q).
- Drives the core's dual-port load interface (we, address_ina/inb, data_ina/inb) for all N coefficients, then holds the last write until the core reports init_done.

Parameters:
N, 256, polynomial length (coefficients per load; must be even)
AW, 8, address width (log2 N)
DW, 16, coefficient width
Q, 3329, modulus
REDUCE, 1, 1 = map signed input into [0,Q); 0 = pass through raw

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low
load_start  in  1  one-cycle pulse, begins a load; honoured only in IDLE or DONE
s_data  in  32  [15:0] = coefficient 2k, [31:16] = coefficient 2k+1, signed two's complement
s_valid  in  1  stream word valid
s_ready  out  1  stream word accepted when s_valid && s_ready
we  out  1  write enable to core
address_ina  out  AW  even coefficient address
address_inb  out  AW  odd coefficient address
data_ina  out  DW  reduced even coefficient
data_inb  out  DW  reduced odd coefficient
init_done  in  1  core has latched its input buffer
busy  out  1  high in LOAD or HOLD
load_done  out  1  level, high in DONE
range_err  out  1  sticky, input outside [-Q, 2Q) seen during current load

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, pair counter=0, s_ready=0, we=0, address_ina=0, address_inb=0, data_ina=0, data_inb=0, busy=0, load_done=0, range_err=0.
- States:
  - IDLE: load_start -> LOAD; counter cleared.
  - LOAD: s_ready=1 while counter < N/2. Each transfer increments the counter. The transfer that makes counter = N/2 moves to HOLD on the same edge.
  - HOLD: s_ready=0, we=1, address/data hold the last pair. init_done=1 sampled -> DONE.
  - DONE: we=0, load_done=1. load_start -> LOAD (counter=0, range_err cleared, load_done drops next cycle).
- load_start in LOAD or HOLD: ignored.
- Latency: a word accepted at edge t appears on the outputs in the cycle after edge t, with we=1 and address_ina=2k, address_inb=2k+1, where k = counter value at acceptance.
- Gaps in LOAD: a cycle with no transfer gives we=0; address/data hold their previous values.
- Back-to-back: one pair per cycle; N/2 = 128 cycles minimum for N=256.
- Reduction (REDUCE=1), per half, x signed 16-bit:
  - x<0 -> x+Q
  - x>=Q -> x−Q
  - else x
  - Result is zero-extended to DW.
  - If x<−Q or x>=2Q, the reduced value is still output (truncated) and range_err sets.
- REDUCE=0: raw bits passed; range_err stays 0.
- range_err clears only on reset or on an accepted load_start.
- init_done already high on entry to HOLD: one HOLD cycle with we=1, then DONE.
- init_done in LOAD: ignored.
- s_valid while not in LOAD: s_ready=0, word not consumed.
- Reset asserted mid-LOAD/HOLD: immediate return to IDLE, partial load discarded, we drops asynchronously.
- Address counter never wraps within a load: s_ready is forced 0 at N/2.

Test Plan:
1. Reset, load_start, 128 back-to-back words, word 0 = 0xFFFE_0000 → first write address_ina=0, address_inb=1, data_ina=0x0000, data_inb=0x0CFF (3327); last write address_ina=254, address_inb=255; s_ready low after 128th transfer.
2. After full load, init_done held low 10 cycles then raised → we=1 throughout HOLD, we=0 and load_done=1 on the cycle after init_done sampled; busy falls with it.
3. s_valid toggled 1/0 every cycle → we pulses only in cycles following transfers; addresses increment by 2 per transfer; 128 writes total.
4. Word 0x0D01_8000 (3329, −32768) → data_inb=0x0000, range_err=1 (−32768 < −Q); a following load_start clears range_err.
5. rst driven low after 50 transfers → all outputs zero immediately; new load_start restarts at address_ina=0.
6. load_start pulsed during LOAD → ignored, counter continues. load_start in DONE → new load, load_done low next cycle.
